// File: rtl/marquee_pkg.sv
// Shared encodings for the marquee sequencer.
// Holds FSM states, mode/direction codes and the position stepper.
package marquee_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DWELL,
      ST_MANUAL
   } state_e;

   localparam logic [1:0] MODE_LEFT   = 2'b00;
   localparam logic [1:0] MODE_RIGHT  = 2'b01;
   localparam logic [1:0] MODE_PING   = 2'b10;
   localparam logic [1:0] MODE_MANUAL = 2'b11;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   // Offset the datapath holds after one rotate in direction d.
   function automatic logic [3:0] pos_step(
      input logic [3:0]  p,
      input logic        d,
      input int unsigned n
   );
      logic [3:0] last;
      last = 4'(n - 1);
      if (d == DIR_LEFT)
         pos_step = (p == last) ? 4'd0 : p + 4'd1;
      else
         pos_step = (p == 4'd0) ? last : p - 4'd1;
   endfunction

endpackage

// File: rtl/marquee_sequencer_tick_prescaler.sv
// Step-period divider with a live speed-selected terminal count.
// Terminal is 2^(TICK_BASE+speed)-1; a late speed drop wraps naturally.
module tick_prescaler #(
   parameter int TICK_BASE = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       tick
);

   localparam int CW = TICK_BASE + 3;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] term;

   always_comb begin
      term  = {CW{1'b1}} >> (2'd3 - speed);
      tick  = (cnt_q == term);
      cnt_d = cnt_q + CW'(1);
      if (clr || tick)
         cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/marquee_sequencer.sv
// Mode-driven sequencer for the nibble-rotating marquee datapath.
// Issues one-cycle shift pulses with direction and tracks the offset.
module marquee_sequencer
   import marquee_pkg::*;
#(
   parameter int TICK_BASE   = 20,
   parameter int NIBBLES     = 10,
   parameter int SPAN        = 9,
   parameter int DWELL_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] mode,
   input  logic [1:0] speed,
   input  logic       step_btn,
   input  logic       man_dir,
   output logic       shift,
   output logic       dir,
   output logic [3:0] pos,
   output logic       busy,
   output logic       at_home
);

   localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

   state_e        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic          leg_q, leg_d;
   logic [3:0]    leg_cnt_q, leg_cnt_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          btn_q;
   logic          shift_q, shift_d;
   logic          dir_q, dir_d;
   logic [3:0]    pos_q, pos_d;
   logic          busy_q, busy_d;
   logic          at_home_q, at_home_d;

   logic tick;
   logic clr;
   logic btn_rise;

   assign clr      = (state_q == ST_IDLE);
   assign btn_rise = step_btn & ~btn_q;

   tick_prescaler #(
      .TICK_BASE (TICK_BASE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .speed (speed),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      leg_d     = leg_q;
      leg_cnt_d = leg_cnt_q;
      dwell_d   = dwell_q;
      shift_d   = 1'b0;
      dir_d     = dir_q;
      pos_d     = pos_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               mode_d    = mode;
               leg_d     = DIR_LEFT;
               leg_cnt_d = 4'd0;
               dwell_d   = '0;
               state_d   = (mode == MODE_MANUAL) ? ST_MANUAL : ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               shift_d = 1'b1;
               case (mode_q)
                  MODE_LEFT:  dir_d = DIR_LEFT;
                  MODE_RIGHT: dir_d = DIR_RIGHT;
                  default:    dir_d = leg_q;
               endcase
               pos_d = pos_step(pos_q, dir_d, NIBBLES);
               if (mode_q == MODE_PING) begin
                  if (int'(leg_cnt_q) == SPAN - 1) begin
                     leg_cnt_d = 4'd0;
                     leg_d     = ~leg_q;
                     dwell_d   = '0;
                     if (DWELL_TICKS > 0)
                        state_d = ST_DWELL;
                  end else begin
                     leg_cnt_d = leg_cnt_q + 4'd1;
                  end
               end
            end
         end
         ST_DWELL: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (int'(dwell_q) == DWELL_TICKS - 1) begin
                  dwell_d = '0;
                  state_d = ST_RUN;
               end else begin
                  dwell_d = dwell_q + DW'(1);
               end
            end
         end
         ST_MANUAL: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (btn_rise) begin
               shift_d = 1'b1;
               dir_d   = man_dir;
               pos_d   = pos_step(pos_q, man_dir, NIBBLES);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status flags track the state/pos being registered this edge.
      busy_d    = (state_d != ST_IDLE);
      at_home_d = (pos_d == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_LEFT;
         leg_q     <= DIR_LEFT;
         leg_cnt_q <= 4'd0;
         dwell_q   <= '0;
         btn_q     <= 1'b0;
         shift_q   <= 1'b0;
         dir_q     <= DIR_LEFT;
         pos_q     <= 4'd0;
         busy_q    <= 1'b0;
         at_home_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         leg_q     <= leg_d;
         leg_cnt_q <= leg_cnt_d;
         dwell_q   <= dwell_d;
         btn_q     <= step_btn;
         shift_q   <= shift_d;
         dir_q     <= dir_d;
         pos_q     <= pos_d;
         busy_q    <= busy_d;
         at_home_q <= at_home_d;
      end
   end

   assign shift   = shift_q;
   assign dir     = dir_q;
   assign pos     = pos_q;
   assign busy    = busy_q;
   assign at_home = at_home_q;

endmodule

// File: tb/tb_marquee_sequencer.sv
// Directed bench for marquee_sequencer (period 4, SPAN 3, dwell 2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_marquee_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       step_btn;
   logic       man_dir;
   logic       shift;
   logic       dir;
   logic [3:0] pos;
   logic       busy;
   logic       at_home;

   int n_chk = 0;
   int n_err = 0;

   marquee_sequencer #(
      .TICK_BASE   (2),
      .NIBBLES     (10),
      .SPAN        (3),
      .DWELL_TICKS (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .speed    (speed),
      .step_btn (step_btn),
      .man_dir  (man_dir),
      .shift    (shift),
      .dir      (dir),
      .pos      (pos),
      .busy     (busy),
      .at_home  (at_home)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      mode     = 2'b00;
      speed    = 2'b00;
      step_btn = 1'b0;
      man_dir  = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_shift"}, shift, 0);
      check({tag, "_dir"}, dir, 1);
      check({tag, "_pos"}, pos, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_home"}, at_home, 1);
   endtask

   task automatic do_start(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // Expect gap-1 quiet cycles, then one shift with the given pos/dir.
   task automatic expect_shift(input string tag, input int gap,
                               input logic [3:0] p, input logic d);
      int seen;
      seen = 0;
      repeat (gap - 1) begin
         cyc();
         if (shift) seen++;
      end
      check({tag, "_quiet"}, seen, 0);
      cyc();
      check({tag, "_shift"}, shift, 1);
      check({tag, "_pos"}, pos, p);
      check({tag, "_dir"}, dir, d);
      check({tag, "_home"}, at_home, (p == 4'd0));
   endtask

   task automatic press(input string tag, input logic d,
                        input logic [3:0] p);
      man_dir  = d;
      step_btn = 1'b1;
      cyc();
      check({tag, "_shift"}, shift, 1);
      check({tag, "_pos"}, pos, p);
      check({tag, "_dir"}, dir, d);
      cyc();
      check({tag, "_once"}, shift, 0);
      step_btn = 1'b0;
      cyc();
   endtask

   initial begin
      int seen;

      // Left rotation, wrap 9 -> 0
      do_reset();
      check_reset_vals("rst");
      do_start(2'b00);
      check("t1_busy", busy, 1);
      check("t1_noshift", shift, 0);
      for (int k = 1; k <= 10; k++)
         expect_shift($sformatf("t1_%0d", k), 4, 4'(k % 10), 1'b1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("t1_stop_busy", busy, 0);

      // Right rotation, then live speed change
      do_reset();
      do_start(2'b01);
      expect_shift("t2_a", 4, 4'd9, 1'b0);
      expect_shift("t2_b", 4, 4'd8, 1'b0);
      expect_shift("t2_c", 4, 4'd7, 1'b0);
      speed = 2'b01;
      expect_shift("t2_d", 8, 4'd6, 1'b0);
      expect_shift("t2_e", 8, 4'd5, 1'b0);

      // Stop on a tick cycle suppresses the shift
      speed = 2'b00;
      repeat (3) cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("t5_stop_shift", shift, 0);
      check("t5_stop_busy", busy, 0);
      check("t5_stop_pos", pos, 5);
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      check("t5_both_busy", busy, 0);
      cyc();
      check("t5_both_busy2", busy, 0);
      start = 1'b0;
      stop  = 1'b0;

      // Ping-pong with dwell
      do_reset();
      do_start(2'b10);
      expect_shift("t3_l1", 4, 4'd1, 1'b1);
      expect_shift("t3_l2", 4, 4'd2, 1'b1);
      expect_shift("t3_l3", 4, 4'd3, 1'b1);
      expect_shift("t3_r1", 12, 4'd2, 1'b0);
      expect_shift("t3_r2", 4, 4'd1, 1'b0);
      expect_shift("t3_r3", 4, 4'd0, 1'b0);
      expect_shift("t3_l4", 12, 4'd1, 1'b1);
      expect_shift("t3_l5", 4, 4'd2, 1'b1);
      expect_shift("t3_l6", 4, 4'd3, 1'b1);
      cyc();
      check("t3_dwell_busy", busy, 1);
      check("t3_dwell_shift", shift, 0);

      // Reset while in DWELL
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_reset_vals("t6_dwell");

      // Manual stepping
      do_reset();
      do_start(2'b11);
      check("t4_busy", busy, 1);
      press("t4_p1", 1'b0, 4'd9);
      man_dir  = 1'b0;
      step_btn = 1'b1;
      seen = 0;
      repeat (20) begin
         cyc();
         if (shift) seen++;
      end
      check("t4_hold_count", seen, 1);
      check("t4_hold_pos", pos, 8);
      step_btn = 1'b0;
      cyc();
      press("t4_p2", 1'b1, 4'd9);

      // Reset pulse that never spans a rising edge
      reset = 1'b1;
      #2;
      reset = 1'b0;
      cyc();
      check("t6_glitch_busy", busy, 1);
      check("t6_glitch_pos", pos, 9);

      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("t4_stop_busy", busy, 0);

      // Button already held on entry to MANUAL
      step_btn = 1'b1;
      cyc();
      do_start(2'b11);
      seen = 0;
      repeat (5) begin
         cyc();
         if (shift) seen++;
      end
      check("t4_held_entry", seen, 0);
      check("t4_held_pos", pos, 9);
      step_btn = 1'b0;
      cyc();
      press("t4_p3", 1'b0, 4'd8);

      // Reset while in MANUAL
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_reset_vals("t6_manual");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/marquee_sequencer.md
Name: marquee_sequencer

Overview:
- Controller that sequences the nibble-rotating seven-segment marquee datapath.
- Generates the rotate-enable pulse (`shift`) and the rotate direction (`dir`), and tracks the current rotation offset.
- Replaces a free-running update counter with a mode-driven FSM: continuous left, continuous right, ping-pong with end dwell, or manual single-step.
- Sits between the board inputs (buttons, switches) and the rotator's update/enable/dir inputs.

Parameters:
- TICK_BASE, 20, base exponent of the step period in clk cycles: period = 2^(TICK_BASE+speed).
- NIBBLES, 10, number of nibble positions in the rotator; `pos` wraps modulo NIBBLES.
- SPAN, 9, shifts per leg in ping-pong mode (1..NIBBLES-1).
- DWELL_TICKS, 4, tick periods paused at each ping-pong end; 0 means no dwell.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; sampled each cycle in IDLE
- stop  in  1  level; forces return to IDLE
- mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 manual; latched on start
- speed  in  2  period exponent offset; applied live
- step_btn  in  1  debounced button level; used in manual mode
- man_dir  in  1  direction for manual steps (1 = left)
- shift  out  1  one-cycle rotate request to the datapath
- dir  out  1  1 = rotate left (toward MSB nibble), 0 = rotate right
- pos  out  4  rotation offset, 0..NIBBLES-1
- busy  out  1  high in any state other than IDLE
- at_home  out  1  pos == 0

Behaviour:
- Reset (sync, at clk edge) sets: state=IDLE, shift=0, dir=1, pos=0, busy=0, at_home=1, tick counter=0, leg=left, dwell count=0, step_btn edge register=0. Reset has priority over every other input. Reset asserted mid-operation takes effect at the next edge with no partial shift.
- All outputs are registered.
- Tick divider:
  - Counter width TICK_BASE+3.
  - Tick occurs when the counter reaches 2^(TICK_BASE+speed)-1; the counter then returns to 0.
  - The counter is cleared on the IDLE->RUN transition.
  - If a speed change makes the terminal value smaller than the current count, the counter wraps naturally; there is no early tick.
- FSM states: IDLE, RUN, DWELL, MANUAL.
  - IDLE: start=1 and stop=0 latches mode. Next state is MANUAL if mode=11, otherwise RUN. leg is set to left. If start and stop are asserted in the same cycle, stay in IDLE.
  - RUN: on a tick, `shift` goes high for exactly one cycle at the next edge.
    - dir = 1 for mode 00, 0 for mode 01, leg for mode 10.
    - The first shift arrives P cycles after start is sampled (P = tick period).
    - Mode 10 only: count shifts in the current leg. After the SPAN-th shift, toggle leg. Go to DWELL if DWELL_TICKS>0, otherwise stay in RUN.
  - DWELL: no shifts. After DWELL_TICKS ticks, return to RUN; the next shift arrives one full period later.
  - MANUAL: each rising edge of step_btn (prev=0, cur=1) produces one shift pulse at the next edge, with dir = man_dir.
    - Holding the button produces exactly one shift.
    - A button already held on entry to MANUAL does not fire.
- stop=1 in RUN, DWELL or MANUAL: go to IDLE at the next edge. No shift is issued that edge, even if a tick or button edge coincides.
- `pos` updates on the same edge `shift` rises. Left shift: pos+1 mod NIBBLES (9->0). Right shift: pos-1 mod NIBBLES (0->9). `pos` therefore shows the offset the datapath holds after it accepts the pulse.
- `dir` holds its last value in IDLE and DWELL.
- `busy` and `at_home` are registered, consistent with state and pos in the same cycle.

Decomposition:
- Package marquee_pkg holds:
  - the state encoding (IDLE/RUN/DWELL/MANUAL);
  - mode constants MODE_LEFT=2'b00, MODE_RIGHT=2'b01, MODE_PING=2'b10, MODE_MANUAL=2'b11;
  - DIR_LEFT=1'b1, DIR_RIGHT=1'b0.
- One natural sub-module: tick_prescaler (counter, speed-selected terminal compare, synchronous clear, tick output).

Test Plan (TICK_BASE=2, speed=0 so period 4, NIBBLES=10, unless stated):
1. reset, then start with mode=00 -> shift high 1 cycle every 4 cycles, first at start+4. dir=1. pos steps 0,1,...,9,0. at_home high at 0 only.
2. mode=01 from reset -> dir=0, pos 9,8,7. speed switched to 1 mid-run -> shift spacing becomes 8 cycles.
3. mode=10, SPAN=3, DWELL_TICKS=2 -> 3 left shifts (pos 1,2,3), then 12 cycles with no shift, then 3 right shifts (pos 2,1,0), then dwell, then left again.
4. mode=11, man_dir=0 -> each step_btn 0->1 edge gives one shift next cycle (pos 0->9). Button held 20 cycles -> exactly one shift. Button high while entering MANUAL -> no shift.
5. stop on a tick cycle in RUN -> no shift, busy=0 next cycle, pos unchanged. start and stop together in IDLE -> stays IDLE.
6. reset asserted in DWELL and in MANUAL -> at the next edge all outputs return to reset values. reset pulsed between edges only -> no effect.
